// File: rtl/sht40_pkg.sv
// Shared encodings and constants for the SHT40 measurement sequencer.
package sht40_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_STOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_NACK = 2'b01,
    ERR_CRC  = 2'b10
  } err_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_START,
    S_W_ADDR,
    S_W_CMD,
    S_W_STOP,
    S_WAIT_CONV,
    S_R_START,
    S_R_ADDR,
    S_R_BYTE,
    S_R_STOP,
    S_CHECK,
    S_NACK_STOP,
    S_RETRY_WAIT
  } state_e;

  localparam logic [7:0] CRC_POLY = 8'h31;
  localparam logic [7:0] CRC_INIT = 8'hFF;

  // Width able to hold the larger of the two wait counts.
  function automatic int wait_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sht40_crc8.sv
// Combinational Sensirion CRC-8 over one 16-bit word, MSB first.
module sht40_crc8
  import sht40_pkg::*;
(
  input  logic [15:0] data,
  output logic [7:0]  crc
);

  always_comb begin
    crc = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ CRC_POLY;
      else                  crc = {crc[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/sht40_measure_sequencer.sv
// Sequences one SHT40 measurement over a byte-level I2C master:
// write command, conversion wait, 6-byte read, CRC check, with NACK retry.
module sht40_measure_sequencer
  import sht40_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR          = 7'h44,
  parameter logic [7:0] MEAS_CMD          = 8'hFD,
  parameter int         CONV_WAIT_CYCLES  = 1000000,
  parameter int         RETRY_WAIT_CYCLES = 100000,
  parameter int         MAX_RETRIES       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Trigger,
  output logic        Cmd_Valid,
  input  logic        Cmd_Ready,
  output logic [1:0]  Cmd_Op,
  output logic [7:0]  Cmd_Wdata,
  output logic        Cmd_Read_Nack,
  input  logic        Resp_Valid,
  input  logic        Resp_Nack,
  input  logic [7:0]  Resp_Rdata,
  output logic        Busy,
  output logic        Data_Valid,
  output logic [15:0] Temp_Raw,
  output logic [15:0] Hum_Raw,
  output logic        Err_Valid,
  output logic [1:0]  Err_Code
);

  localparam int WAIT_W  = wait_width(CONV_WAIT_CYCLES, RETRY_WAIT_CYCLES);
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [WAIT_W-1:0]  CONV_LAST   = WAIT_W'(CONV_WAIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  RETRY_LAST  = WAIT_W'(RETRY_WAIT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  state_e              state_reg, state_next;
  logic                sent_reg, sent_next;
  logic                phase_reg, phase_next;    // 0 = write phase, 1 = read phase
  logic                fatal_reg, fatal_next;
  logic [RETRY_W-1:0]  retry_cnt_reg, retry_cnt_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [2:0]          byte_idx_reg, byte_idx_next;
  logic [15:0]         temp_reg, temp_next;
  logic [15:0]         hum_reg, hum_next;
  logic                data_valid_reg, data_valid_next;
  logic                err_valid_reg, err_valid_next;
  logic [1:0]          err_code_reg, err_code_next;
  logic [7:0]          rx_reg [6];

  logic       resp;
  logic       is_cmd;
  logic       nack_hit;
  logic       rx_we;
  logic [7:0] crc_temp, crc_hum;

  // A response only counts once our command has been accepted.
  assign resp  = sent_reg && Resp_Valid;
  assign rx_we = (state_reg == S_R_BYTE) && resp;

  sht40_crc8 u_crc_temp (.data({rx_reg[0], rx_reg[1]}), .crc(crc_temp));
  sht40_crc8 u_crc_hum  (.data({rx_reg[3], rx_reg[4]}), .crc(crc_hum));

  always_comb begin
    state_next      = state_reg;
    sent_next       = sent_reg;
    phase_next      = phase_reg;
    fatal_next      = fatal_reg;
    retry_cnt_next  = retry_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    byte_idx_next   = byte_idx_reg;
    temp_next       = temp_reg;
    hum_next        = hum_reg;
    data_valid_next = 1'b0;
    err_valid_next  = 1'b0;
    err_code_next   = err_code_reg;
    Cmd_Valid       = 1'b0;
    Cmd_Op          = OP_START;
    Cmd_Wdata       = 8'h00;
    Cmd_Read_Nack   = 1'b0;
    is_cmd          = 1'b0;
    nack_hit        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (Trigger && !data_valid_reg && !err_valid_reg) begin
          state_next     = S_W_START;
          phase_next     = 1'b0;
          fatal_next     = 1'b0;
          retry_cnt_next = '0;
        end
      end
      S_W_START: begin
        is_cmd = 1'b1;
        Cmd_Op = OP_START;
        if (resp) state_next = S_W_ADDR;
      end
      S_W_ADDR: begin
        is_cmd    = 1'b1;
        Cmd_Op    = OP_WRITE;
        Cmd_Wdata = {I2C_ADDR, 1'b0};
        if (resp) begin
          if (Resp_Nack) nack_hit = 1'b1;
          else begin
            retry_cnt_next = '0;
            state_next     = S_W_CMD;
          end
        end
      end
      S_W_CMD: begin
        is_cmd    = 1'b1;
        Cmd_Op    = OP_WRITE;
        Cmd_Wdata = MEAS_CMD;
        if (resp) begin
          if (Resp_Nack) nack_hit = 1'b1;
          else           state_next = S_W_STOP;
        end
      end
      S_W_STOP: begin
        is_cmd = 1'b1;
        Cmd_Op = OP_STOP;
        if (resp) begin
          wait_cnt_next = '0;
          state_next    = S_WAIT_CONV;
        end
      end
      S_WAIT_CONV: begin
        if (wait_cnt_reg == CONV_LAST) begin
          wait_cnt_next = '0;
          phase_next    = 1'b1;
          state_next    = S_R_START;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      S_R_START: begin
        is_cmd = 1'b1;
        Cmd_Op = OP_START;
        if (resp) state_next = S_R_ADDR;
      end
      S_R_ADDR: begin
        is_cmd    = 1'b1;
        Cmd_Op    = OP_WRITE;
        Cmd_Wdata = {I2C_ADDR, 1'b1};
        if (resp) begin
          if (Resp_Nack) nack_hit = 1'b1;
          else begin
            retry_cnt_next = '0;
            byte_idx_next  = 3'd0;
            state_next     = S_R_BYTE;
          end
        end
      end
      S_R_BYTE: begin
        is_cmd        = 1'b1;
        Cmd_Op        = OP_READ;
        Cmd_Read_Nack = (byte_idx_reg == 3'd5);
        if (resp) begin
          if (byte_idx_reg == 3'd5) state_next = S_R_STOP;
          else                      byte_idx_next = byte_idx_reg + 3'd1;
        end
      end
      S_R_STOP: begin
        is_cmd = 1'b1;
        Cmd_Op = OP_STOP;
        if (resp) state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = S_IDLE;
        if (crc_temp == rx_reg[2] && crc_hum == rx_reg[5]) begin
          temp_next       = {rx_reg[0], rx_reg[1]};
          hum_next        = {rx_reg[3], rx_reg[4]};
          data_valid_next = 1'b1;
        end else begin
          err_valid_next = 1'b1;
          err_code_next  = ERR_CRC;
        end
      end
      S_NACK_STOP: begin
        is_cmd = 1'b1;
        Cmd_Op = OP_STOP;
        if (resp) begin
          if (fatal_reg) begin
            fatal_next     = 1'b0;
            err_valid_next = 1'b1;
            err_code_next  = ERR_NACK;
            state_next     = S_IDLE;
          end else begin
            wait_cnt_next = '0;
            state_next    = S_RETRY_WAIT;
          end
        end
      end
      S_RETRY_WAIT: begin
        if (wait_cnt_reg == RETRY_LAST) begin
          wait_cnt_next = '0;
          state_next    = phase_reg ? S_R_START : S_W_START;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // The STOP after the final allowed NACK ends the transaction in error.
    if (nack_hit) begin
      state_next = S_NACK_STOP;
      if (retry_cnt_reg == RETRY_LIMIT) fatal_next = 1'b1;
      else                              retry_cnt_next = retry_cnt_reg + 1'b1;
    end

    if (is_cmd) begin
      Cmd_Valid = !sent_reg;
      if (!sent_reg && Cmd_Ready) sent_next = 1'b1;
      if (resp)                   sent_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      sent_reg       <= 1'b0;
      phase_reg      <= 1'b0;
      fatal_reg      <= 1'b0;
      retry_cnt_reg  <= '0;
      wait_cnt_reg   <= '0;
      byte_idx_reg   <= 3'd0;
      temp_reg       <= 16'h0000;
      hum_reg        <= 16'h0000;
      data_valid_reg <= 1'b0;
      err_valid_reg  <= 1'b0;
      err_code_reg   <= ERR_NONE;
    end else begin
      state_reg      <= state_next;
      sent_reg       <= sent_next;
      phase_reg      <= phase_next;
      fatal_reg      <= fatal_next;
      retry_cnt_reg  <= retry_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      byte_idx_reg   <= byte_idx_next;
      temp_reg       <= temp_next;
      hum_reg        <= hum_next;
      data_valid_reg <= data_valid_next;
      err_valid_reg  <= err_valid_next;
      err_code_reg   <= err_code_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) rx_reg[i] <= 8'h00;
    end else if (rx_we) begin
      for (int i = 0; i < 6; i++) begin
        if (byte_idx_reg == 3'(i)) rx_reg[i] <= Resp_Rdata;
      end
    end
  end

  assign Busy       = (state_reg != S_IDLE);
  assign Data_Valid = data_valid_reg;
  assign Err_Valid  = err_valid_reg;
  assign Err_Code   = err_code_reg;
  assign Temp_Raw   = temp_reg;
  assign Hum_Raw    = hum_reg;

endmodule

// File: tb/tb_sht40_measure_sequencer.sv
// Scoreboard bench: an I2C master/slave model answers commands, a reference
// model predicts the command stream and results, a monitor compares them.
module tb_sht40_measure_sequencer;

  localparam int P_CONV  = 40;
  localparam int P_RETRY = 25;
  localparam int P_MAXR  = 3;
  localparam logic [1:0] OP_START = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_STOP = 2'b11;

  logic        clk = 1'b0;
  logic        rst, Trigger;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Read_Nack;
  logic [1:0]  Cmd_Op;
  logic [7:0]  Cmd_Wdata;
  logic        Resp_Valid, Resp_Nack;
  logic [7:0]  Resp_Rdata;
  logic        Busy, Data_Valid, Err_Valid;
  logic [15:0] Temp_Raw, Hum_Raw;
  logic [1:0]  Err_Code;

  sht40_measure_sequencer #(
    .I2C_ADDR(7'h44), .MEAS_CMD(8'hFD), .CONV_WAIT_CYCLES(P_CONV),
    .RETRY_WAIT_CYCLES(P_RETRY), .MAX_RETRIES(P_MAXR)
  ) dut (
    .clk(clk), .rst(rst), .Trigger(Trigger),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
    .Cmd_Wdata(Cmd_Wdata), .Cmd_Read_Nack(Cmd_Read_Nack),
    .Resp_Valid(Resp_Valid), .Resp_Nack(Resp_Nack), .Resp_Rdata(Resp_Rdata),
    .Busy(Busy), .Data_Valid(Data_Valid), .Temp_Raw(Temp_Raw), .Hum_Raw(Hum_Raw),
    .Err_Valid(Err_Valid), .Err_Code(Err_Code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] wdata;
    logic       rnack;
    int         gap;     // idle cycles since previous response, -1 = don't care
  } exp_cmd_t;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [15:0] temp;
    logic [15:0] hum;
  } exp_res_t;

  exp_cmd_t exp_cmd_q[$];
  exp_res_t exp_res_q[$];

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs
  int         w_nack_left = 0;
  int         r_nack_left = 0;
  int         read_cnt    = 0;
  int         bp_cycles   = 0;
  logic [7:0] rbytes [6];

  // Reference-model view of the result registers
  logic [15:0] model_temp = 16'h0;
  logic [15:0] model_hum  = 16'h0;
  logic [1:0]  model_code = 2'b00;

  function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    c = 8'hFF ^ a;
    for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    c = c ^ b;
    for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    return c;
  endfunction

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] wd, input logic rn, input int gap);
    exp_cmd_t e;
    e.op = op; e.wdata = wd; e.rnack = rn; e.gap = gap;
    exp_cmd_q.push_back(e);
  endtask

  task automatic push_res(input bit is_err);
    exp_res_t r;
    r.is_err = is_err; r.code = model_code; r.temp = model_temp; r.hum = model_hum;
    exp_res_q.push_back(r);
  endtask

  // Whole-transaction prediction from address NACK counts and sensor bytes.
  task automatic build_expected(input int wn, input int rn, input logic [7:0] b [6]);
    int nw, nr;
    nw = (wn > P_MAXR) ? P_MAXR + 1 : wn;
    for (int a = 0; a < nw; a++) begin
      push_cmd(OP_START, 8'h00, 1'b0, (a == 0) ? -1 : P_RETRY);
      push_cmd(OP_WRITE, 8'h88, 1'b0, 0);
      push_cmd(OP_STOP,  8'h00, 1'b0, 0);
    end
    if (wn > P_MAXR) begin
      model_code = 2'b01;
      push_res(1'b1);
      return;
    end
    push_cmd(OP_START, 8'h00, 1'b0, (nw == 0) ? -1 : P_RETRY);
    push_cmd(OP_WRITE, 8'h88, 1'b0, 0);
    push_cmd(OP_WRITE, 8'hFD, 1'b0, 0);
    push_cmd(OP_STOP,  8'h00, 1'b0, 0);
    nr = (rn > P_MAXR) ? P_MAXR + 1 : rn;
    for (int a = 0; a < nr; a++) begin
      push_cmd(OP_START, 8'h00, 1'b0, (a == 0) ? P_CONV : P_RETRY);
      push_cmd(OP_WRITE, 8'h89, 1'b0, 0);
      push_cmd(OP_STOP,  8'h00, 1'b0, 0);
    end
    if (rn > P_MAXR) begin
      model_code = 2'b01;
      push_res(1'b1);
      return;
    end
    push_cmd(OP_START, 8'h00, 1'b0, (nr == 0) ? P_CONV : P_RETRY);
    push_cmd(OP_WRITE, 8'h89, 1'b0, 0);
    for (int i = 0; i < 6; i++) push_cmd(OP_READ, 8'h00, (i == 5), 0);
    push_cmd(OP_STOP, 8'h00, 1'b0, 0);
    if (crc8(b[0], b[1]) == b[2] && crc8(b[3], b[4]) == b[5]) begin
      model_temp = {b[0], b[1]};
      model_hum  = {b[3], b[4]};
      push_res(1'b0);
    end else begin
      model_code = 2'b10;
      push_res(1'b1);
    end
  endtask

  // Master/slave model: accepts commands (with optional backpressure) and answers.
  initial begin : slave
    logic [1:0] cap_op;
    logic [7:0] cap_wd;
    bit pend, busy_s, seen;
    int stall, delay;
    pend = 0; busy_s = 0; seen = 0; stall = 0; delay = 0; cap_op = 0; cap_wd = 0;
    Cmd_Ready = 0; Resp_Valid = 0; Resp_Nack = 0; Resp_Rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      Resp_Valid = 0;
      Resp_Nack  = 0;
      if (rst) begin
        Cmd_Ready = 0; pend = 0; busy_s = 0; seen = 0;
      end else if (pend) begin
        Cmd_Ready = 0; pend = 0; busy_s = 1; delay = $urandom_range(1, 3);
      end else if (busy_s) begin
        if (delay > 1) delay--;
        else begin
          Resp_Valid = 1; busy_s = 0;
          if (cap_op == OP_WRITE && cap_wd == 8'h88 && w_nack_left > 0) begin
            Resp_Nack = 1; w_nack_left--;
          end else if (cap_op == OP_WRITE && cap_wd == 8'h89) begin
            if (r_nack_left > 0) begin Resp_Nack = 1; r_nack_left--; end
            else read_cnt = 0;
          end else if (cap_op == OP_READ) begin
            Resp_Rdata = (read_cnt < 6) ? rbytes[read_cnt] : 8'h00;
            Resp_Nack  = 1'($urandom_range(0, 1));   // must be ignored on reads
            read_cnt++;
          end
        end
      end else if (Cmd_Valid) begin
        if (!seen) begin seen = 1; stall = bp_cycles; end
        if (stall > 0) stall--;
        else begin
          Cmd_Ready = 1; pend = 1; seen = 0; cap_op = Cmd_Op; cap_wd = Cmd_Wdata;
        end
      end
    end
  end

  // Monitor: compares accepted commands and result pulses against the queues.
  initial begin : monitor
    int cyc, last_resp, first_cyc, gap;
    bit prev_pending, stable;
    logic [1:0] h_op;
    logic [7:0] h_wd;
    logic h_rn;
    exp_cmd_t e;
    exp_res_t r;
    cyc = 0; last_resp = 0; first_cyc = 0; gap = 0; prev_pending = 0; stable = 1;
    h_op = 0; h_wd = 0; h_rn = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_pending = 0;
      end else begin
        if (Resp_Valid) last_resp = cyc;
        if (Cmd_Valid) begin
          if (!prev_pending) begin
            h_op = Cmd_Op; h_wd = Cmd_Wdata; h_rn = Cmd_Read_Nack;
            stable = 1; first_cyc = cyc;
          end else if (Cmd_Op != h_op || Cmd_Wdata != h_wd || Cmd_Read_Nack != h_rn) begin
            stable = 0;
          end
          if (Cmd_Ready) begin
            checks++;
            gap = first_cyc - last_resp - 1;
            if (exp_cmd_q.size() == 0) begin
              errors++;
              $display("FAIL cmd_extra: got op=%0d wdata=%h, expected no command", Cmd_Op, Cmd_Wdata);
            end else begin
              e = exp_cmd_q.pop_front();
              if (!stable || Cmd_Op != e.op ||
                  (e.op == OP_WRITE && Cmd_Wdata != e.wdata) ||
                  (e.op == OP_READ && Cmd_Read_Nack != e.rnack) ||
                  (e.gap >= 0 && gap != e.gap)) begin
                errors++;
                $display("FAIL cmd: got op=%0d wdata=%h rnack=%0d gap=%0d stable=%0d, expected op=%0d wdata=%h rnack=%0d gap=%0d stable=1",
                         Cmd_Op, Cmd_Wdata, Cmd_Read_Nack, gap, stable, e.op, e.wdata, e.rnack, e.gap);
              end
            end
          end
        end
        prev_pending = Cmd_Valid && !Cmd_Ready;
        if (Data_Valid || Err_Valid) begin
          checks++;
          if (exp_res_q.size() == 0) begin
            errors++;
            $display("FAIL result_extra: got dv=%0d ev=%0d, expected no result", Data_Valid, Err_Valid);
          end else begin
            r = exp_res_q.pop_front();
            if (Data_Valid != !r.is_err || Err_Valid != r.is_err || Err_Code != r.code ||
                Temp_Raw != r.temp || Hum_Raw != r.hum) begin
              errors++;
              $display("FAIL result: got dv=%0d ev=%0d code=%0d temp=%h hum=%h, expected dv=%0d ev=%0d code=%0d temp=%h hum=%h",
                       Data_Valid, Err_Valid, Err_Code, Temp_Raw, Hum_Raw,
                       !r.is_err, r.is_err, r.code, r.temp, r.hum);
            end
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    check_val(name, {Cmd_Valid, Cmd_Op, Cmd_Wdata, Cmd_Read_Nack, Busy, Data_Valid,
                     Err_Valid, Err_Code, Temp_Raw, Hum_Raw}, 64'h0);
  endtask

  task automatic start_txn(input int wn, input int rn, input logic [7:0] b [6], input int bp);
    build_expected(wn, rn, b);
    w_nack_left = wn; r_nack_left = rn; rbytes = b; bp_cycles = bp;
    @(negedge clk);
    Trigger = 1;
    @(negedge clk);
    Trigger = 0;
    check_val("busy_after_trigger", 64'(Busy), 64'd1);
  endtask

  task automatic run_txn(input int wn, input int rn, input logic [7:0] b [6], input int bp, input bit busy_trig);
    bit done;
    start_txn(wn, rn, b, bp);
    done = 0;
    for (int n = 0; n < 6000 && !done; n++) begin
      @(negedge clk);
      Trigger = 0;
      if (Data_Valid || Err_Valid) begin
        done = 1;
        if (busy_trig) Trigger = 1;   // coincident with the result pulse: must be dropped
      end else if (busy_trig && Busy && $urandom_range(0, 15) == 0) begin
        Trigger = 1;
      end
    end
    @(negedge clk);
    Trigger = 0;
    check_val("txn_completed", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    check_val("idle_after_txn", 64'(Busy), 64'd0);
    check_val("cmds_left", 64'(exp_cmd_q.size()), 64'd0);
    check_val("results_left", 64'(exp_res_q.size()), 64'd0);
    exp_cmd_q.delete();
    exp_res_q.delete();
  endtask

  task automatic reset_mid_read(input logic [7:0] b [6]);
    bit found;
    start_txn(0, 0, b, 0);
    found = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (read_cnt == 3 && Cmd_Valid && Cmd_Op == OP_READ) begin
        found = 1;
        break;
      end
    end
    check_val("reached_read_idx3", 64'(found), 64'd1);
    rst = 1;
    @(negedge clk);
    check_zero("reset_mid_outputs");
    rst = 0;
    exp_cmd_q.delete();
    exp_res_q.delete();
    model_temp = 16'h0; model_hum = 16'h0; model_code = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    logic [7:0] b [6];
    int wn, rn;
    rst = 1; Trigger = 0;
    repeat (4) @(negedge clk);
    check_zero("reset_outputs");
    rst = 0;
    repeat (2) @(negedge clk);

    b = '{8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93};
    run_txn(0, 0, b, 0, 0);                       // nominal
    b[2] = 8'h93;
    run_txn(0, 0, b, 0, 0);                       // temperature CRC fail
    b = '{8'h61, 8'h2A, 8'h00, 8'h8C, 8'h10, 8'h00};
    b[2] = crc8(b[0], b[1]);
    b[5] = crc8(b[3], b[4]);
    run_txn(0, 2, b, 0, 0);                       // read address NACK twice
    run_txn(9, 0, b, 0, 0);                       // write address NACK forever
    b[0] = 8'h5C; b[2] = crc8(b[0], b[1]);
    run_txn(0, 0, b, 5, 1);                       // backpressure + Trigger while busy
    run_txn(0, 4, b, 1, 0);                       // read address NACK limit

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
      b[2] = crc8(b[0], b[1]);
      b[5] = crc8(b[3], b[4]);
      if ($urandom_range(0, 3) == 0) b[5] = b[5] ^ 8'h5A;
      wn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_txn(wn, rn, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    b = '{8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93};
    reset_mid_read(b);
    b = '{8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD, 8'h00};
    b[2] = crc8(b[0], b[1]);
    b[5] = crc8(b[3], b[4]);
    run_txn(0, 0, b, 2, 0);                       // clean run after mid-read reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sht40_measure_sequencer.md
Name: sht40_measure_sequencer

Overview:
Controller that sequences one SHT40 measurement transaction over the team's byte-level I2C master: write phase (START, addr+W, command, STOP), conversion wait, read phase (START, addr+R, 6 bytes, STOP), then CRC check. Sits between the application (trigger/result) and the I2C master that drives the SCL/SDA line engines. It owns all bus sequencing, NACK retry and error reporting.

Parameters:
I2C_ADDR, 7'h44, sensor 7-bit address
MEAS_CMD, 8'hFD, measurement command (high precision)
CONV_WAIT_CYCLES, 1000000, clk cycles between write-phase STOP and read-phase START (10 ms @ 100 MHz)
RETRY_WAIT_CYCLES, 100000, clk cycles before re-attempting after a NACK
MAX_RETRIES, 3, NACK retries per phase before error

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
Trigger  in  1  one-cycle request to start a measurement; ignored while Busy
Cmd_Valid  out  1  command to I2C master valid
Cmd_Ready  in  1  master accepts command
Cmd_Op  out  2  00 START, 01 WRITE, 10 READ, 11 STOP
Cmd_Wdata  out  8  byte for WRITE
Cmd_Read_Nack  out  1  for READ: 1 = master sends NACK after byte (last byte)
Resp_Valid  in  1  one pulse per completed command
Resp_Nack  in  1  with Resp_Valid after WRITE: slave NACKed
Resp_Rdata  in  8  with Resp_Valid after READ
Busy  out  1  transaction in progress
Data_Valid  out  1  one-cycle pulse, results good
Temp_Raw  out  16  raw temperature word
Hum_Raw  out  16  raw humidity word
Err_Valid  out  1  one-cycle pulse, transaction failed
Err_Code  out  2  01 NACK limit, 10 CRC fail

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst).
- Reset: all outputs 0, FSM to IDLE, counters 0. rst mid-transaction aborts immediately; no STOP issued (master reset separately).
- Command handshake: Cmd_Op/Cmd_Wdata/Cmd_Read_Nack stable while Cmd_Valid=1 && Cmd_Ready=0. Exactly one outstanding command; next command is not presented until Resp_Valid for the previous one.
- Busy=1 from cycle after Trigger accepted until cycle of Data_Valid/Err_Valid pulse.
- FSM states:
  - IDLE: Trigger -> W_START.
  - W_START: issue START.
  - W_ADDR: WRITE {I2C_ADDR,1'b0}.
  - W_CMD: WRITE MEAS_CMD.
  - W_STOP: issue STOP.
  - WAIT_CONV: count CONV_WAIT_CYCLES.
  - R_START: issue START.
  - R_ADDR: WRITE {I2C_ADDR,1'b1}.
  - R_BYTE: READ x6, index 0..5; Cmd_Read_Nack=1 only for index 5.
  - R_STOP: issue STOP.
  - CHECK: CRC check.
  - IDLE.
- NACK on W_ADDR/W_CMD/R_ADDR: issue STOP (NACK_STOP), increment phase retry counter, wait RETRY_WAIT_CYCLES, restart that phase (W_START or R_START).
  - Retry counter resets on successful address ACK of each phase.
  - When counter == MAX_RETRIES on a further NACK: STOP, Err_Valid=1, Err_Code=01, IDLE. Total attempts per phase = MAX_RETRIES+1.
- Byte mapping: b0:b1 = Temp MSB:LSB, b2 = Temp CRC, b3:b4 = Hum MSB:LSB, b5 = Hum CRC.
- CRC-8: poly 0x31, init 0xFF, no reflection, xorout 0x00, over each 2-byte word.
- CHECK, one cycle:
  - Both CRCs match: Temp_Raw/Hum_Raw update the same cycle Data_Valid pulses.
  - Either CRC fails: Temp_Raw/Hum_Raw hold previous values; Err_Valid=1, Err_Code=10.
- Err_Code holds until the next Err_Valid.
- Trigger during Busy is dropped (no queueing). Trigger coincident with Data_Valid/Err_Valid is dropped.
- Resp_Nack on a READ response is ignored.
- Wait counters: width ceil(log2(max(CONV_WAIT_CYCLES, RETRY_WAIT_CYCLES)+1)); counter reaches N-1 then advances, giving exactly N cycles.

Decomposition:
- Package sht40_pkg: Cmd_Op encodings, Err_Code encodings, FSM state enum, CRC poly/init constants.
- Sub-module sht40_crc8: combinational 2-byte CRC, in 16-bit word, out 8-bit CRC. Instantiated twice or muxed.

Test Plan:
- Nominal: Trigger; slave ACKs all; read bytes BE EF 92 66 66 93 -> commands START, WRITE 88, WRITE FD, STOP, exactly CONV_WAIT_CYCLES idle, START, WRITE 89, 6 READs (last Nack=1), STOP. Then Data_Valid=1 with Temp_Raw=BEEF, Hum_Raw=6666.
- CRC fail: same, but byte2=93 -> Err_Valid, Err_Code=10, Temp_Raw/Hum_Raw unchanged from prior values.
- Read-addr NACK twice then ACK -> two STOP+RETRY_WAIT cycles, third R_ADDR succeeds, Data_Valid pulses.
- W_ADDR NACK always (MAX_RETRIES=3) -> 4 address attempts, final STOP, Err_Valid, Err_Code=01, Busy drops.
- Backpressure: Cmd_Ready low 5 cycles on each command -> Cmd_* stable throughout, sequence unchanged. Trigger while Busy -> ignored, one transaction only.
- rst asserted during R_BYTE index 3 -> next cycle all outputs 0, IDLE. Subsequent Trigger runs a clean transaction.
